// File: rtl/axis_averager_sequencer.sv
// Run controller that gates triggered ADC frames into an accumulating averager,
// then injects one zero-valued readout frame to flush the accumulator.
module axis_averager_sequencer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16,
    parameter int FRAME_WIDTH      = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        trg_flag,
    input  logic [CNTR_WIDTH-1:0]       cfg_frame_len,
    input  logic [FRAME_WIDTH-1:0]      cfg_frame_num,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        avg_reset,
    output logic                        busy,
    output logic                        done,
    output logic [FRAME_WIDTH-1:0]      frame_cntr,
    output logic [CNTR_WIDTH-1:0]       sample_cntr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FRAME,
        ST_READOUT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNTR_WIDTH-1:0]  len_q, len_d, sample_d;
    logic [FRAME_WIDTH-1:0] num_q, num_d, frame_d;
    logic                   beat, cfg_ok, last_sample, last_frame;

    // Stream path is zero-latency: only FRAME passes samples, READOUT forces zeros.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b1;
        case (state_q)
            ST_FRAME: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
            end
            ST_READOUT: m_axis_tvalid = 1'b1;
            default: ;
        endcase
    end

    assign beat        = m_axis_tvalid & m_axis_tready;
    assign cfg_ok      = (cfg_frame_len != '0) && (cfg_frame_num != '0);
    assign last_sample = (sample_cntr == len_q - CNTR_WIDTH'(1));
    assign last_frame  = (frame_cntr == num_q - FRAME_WIDTH'(1));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        num_d    = num_q;
        sample_d = sample_cntr;
        frame_d  = frame_cntr;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && cfg_ok) begin
                    len_d    = cfg_frame_len;
                    num_d    = cfg_frame_num;
                    sample_d = '0;
                    frame_d  = '0;
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED: if (trg_flag) state_d = ST_FRAME;
            ST_FRAME: begin
                if (beat) begin
                    if (last_sample) begin
                        sample_d = '0;
                        frame_d  = frame_cntr + FRAME_WIDTH'(1);
                        state_d  = last_frame ? ST_READOUT : ST_ARMED;
                    end else begin
                        sample_d = sample_cntr + CNTR_WIDTH'(1);
                    end
                end
            end
            ST_READOUT: begin
                if (beat) begin
                    if (last_sample) begin
                        sample_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        sample_d = sample_cntr + CNTR_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides any start seen in the same cycle.
        if (abort) begin
            state_d  = ST_IDLE;
            sample_d = '0;
            frame_d  = '0;
        end
    end

    // Status flags are registered from the next state so they change with it.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (areset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            num_q       <= '0;
            sample_cntr <= '0;
            frame_cntr  <= '0;
            avg_reset   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            num_q       <= num_d;
            sample_cntr <= sample_d;
            frame_cntr  <= frame_d;
            avg_reset   <= (state_d == ST_IDLE);
            busy        <= (state_d == ST_ARMED) || (state_d == ST_FRAME) || (state_d == ST_READOUT);
            done        <= (state_d == ST_DONE);
        end
    end

endmodule
